// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle controller: state codes, datapath mux
// select codes and the FP instruction match used by the controller and decoder.
package multicycle_ctrl_pkg;

    localparam logic [3:0] ST_FETCH   = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_MEMADR  = 4'd2;
    localparam logic [3:0] ST_MEMRD   = 4'd3;
    localparam logic [3:0] ST_MEMWB   = 4'd4;
    localparam logic [3:0] ST_MEMWR   = 4'd5;
    localparam logic [3:0] ST_EXECR   = 4'd6;
    localparam logic [3:0] ST_EXECI   = 4'd7;
    localparam logic [3:0] ST_ALUWB   = 4'd8;
    localparam logic [3:0] ST_BRANCH  = 4'd9;
    localparam logic [3:0] ST_FPSTART = 4'd10;
    localparam logic [3:0] ST_FPWAIT  = 4'd11;
    localparam logic [3:0] ST_FPABORT = 4'd12;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] ALUB_REG  = 2'b00;
    localparam logic [1:0] ALUB_IMM  = 2'b01;
    localparam logic [1:0] ALUB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Funct[5:1] pattern that turns a data-processing AND into an FP op
    localparam logic [4:0] FP_FUNCT_MATCH = 5'b00000;

    function automatic logic is_fpinst(input logic [1:0] op, input logic [5:0] funct);
        return (op == OP_DP) && (funct[5:1] == FP_FUNCT_MATCH);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/control bundle between the multicycle controller and the datapath.
interface multicycle_ctrl_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       fp_done;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       ALUOp;
    logic       fp_start;
    logic       fp_err;
    logic [3:0] state_dbg;

    modport master (
        output Op, Funct, fp_done,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW,
               MemW, Branch, ALUOp, fp_start, fp_err, state_dbg
    );

    modport slave (
        input  Op, Funct, fp_done,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW,
               MemW, Branch, ALUOp, fp_start, fp_err, state_dbg
    );
endinterface

// File: rtl/multicycle_ctrl_fpwait.sv
// FP wait-cycle counter: cleared on FP start, counts while waiting, flags
// the last permitted wait cycle.
module multicycle_ctrl_fpwait #(
    parameter int unsigned FP_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (enable_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == CNT_W'(FP_TIMEOUT - 1));
endmodule

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multicycle ARM-subset core, including the FP
// unit start/done handshake with timeout. Strobes are unconditioned.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned FP_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 7
) (
    input  logic            clk,
    input  logic            reset,
    multicycle_ctrl_if.slave bus
);
    logic [3:0] state_q, state_d;
    logic       fp_expired;
    logic       irwrite, nextpc, regw, memw, branch, fpstart, fperr;
    logic       adrsrc, alusrca, aluop;
    logic [1:0] alusrcb, resultsrc;

    multicycle_ctrl_fpwait #(
        .FP_TIMEOUT(FP_TIMEOUT),
        .CNT_W     (CNT_W)
    ) u_fpwait (
        .clk      (clk),
        .rst_n    (reset),
        .clear_i  (state_q == ST_FPSTART),
        .enable_i (state_q == ST_FPWAIT),
        .expired_o(fp_expired)
    );

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (bus.Op)
                    OP_MEM:  state_d = ST_MEMADR;
                    OP_BR:   state_d = ST_BRANCH;
                    OP_DP: begin
                        if (is_fpinst(bus.Op, bus.Funct))
                            state_d = ST_FPSTART;
                        else if (bus.Funct[5])
                            state_d = ST_EXECI;
                        else
                            state_d = ST_EXECR;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR:  state_d = bus.Funct[0] ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:   state_d = ST_MEMWB;
            ST_EXECR:   state_d = ST_ALUWB;
            ST_EXECI:   state_d = ST_ALUWB;
            ST_FPSTART: state_d = ST_FPWAIT;
            // fp_done wins over a coincident timeout
            ST_FPWAIT: begin
                if (bus.fp_done)
                    state_d = ST_ALUWB;
                else if (fp_expired)
                    state_d = ST_FPABORT;
                else
                    state_d = ST_FPWAIT;
            end
            default:    state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= ST_FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        irwrite = 1'b0; nextpc = 1'b0; regw = 1'b0; memw = 1'b0;
        branch = 1'b0; fpstart = 1'b0; fperr = 1'b0;
        adrsrc = 1'b0; alusrca = 1'b0; aluop = 1'b0;
        alusrcb = ALUB_REG; resultsrc = RES_ALUOUT;
        case (state_q)
            ST_FETCH: begin
                alusrca = 1'b1; alusrcb = ALUB_FOUR; resultsrc = RES_ALU;
                irwrite = 1'b1; nextpc = 1'b1;
            end
            ST_DECODE: begin
                alusrca = 1'b1; alusrcb = ALUB_FOUR; resultsrc = RES_ALU;
            end
            ST_MEMADR:  alusrcb = ALUB_IMM;
            ST_MEMRD:   adrsrc = 1'b1;
            ST_MEMWB: begin
                resultsrc = RES_RDATA; regw = 1'b1;
            end
            ST_MEMWR: begin
                adrsrc = 1'b1; memw = 1'b1;
            end
            ST_EXECR:   aluop = 1'b1;
            ST_EXECI: begin
                aluop = 1'b1; alusrcb = ALUB_IMM;
            end
            ST_ALUWB:   regw = 1'b1;
            ST_BRANCH: begin
                alusrcb = ALUB_IMM; resultsrc = RES_ALU; branch = 1'b1;
            end
            ST_FPSTART: begin
                aluop = 1'b1; fpstart = 1'b1;
            end
            ST_FPWAIT:  aluop = 1'b1;
            ST_FPABORT: fperr = 1'b1;
            default: ;
        endcase
    end

    // Strobes are masked combinationally so nothing fires while reset is low
    assign bus.IRWrite   = irwrite & reset;
    assign bus.NextPC    = nextpc  & reset;
    assign bus.RegW      = regw    & reset;
    assign bus.MemW      = memw    & reset;
    assign bus.Branch    = branch  & reset;
    assign bus.fp_start  = fpstart & reset;
    assign bus.fp_err    = fperr   & reset;
    assign bus.AdrSrc    = adrsrc;
    assign bus.ALUSrcA   = alusrca;
    assign bus.ALUSrcB   = alusrcb;
    assign bus.ResultSrc = resultsrc;
    assign bus.ALUOp     = aluop;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and checks state and the full output vector against hand values.
module tb_multicycle_ctrl;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    multicycle_ctrl_if bus_if ();

    multicycle_ctrl #(
        .FP_TIMEOUT(4),
        .CNT_W     (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,NextPC,RegW,MemW,Branch,ALUOp,fp_start,fp_err}
    logic [13:0] obs_vec;
    assign obs_vec = {bus_if.IRWrite, bus_if.AdrSrc, bus_if.ALUSrcA, bus_if.ALUSrcB,
                      bus_if.ResultSrc, bus_if.NextPC, bus_if.RegW, bus_if.MemW,
                      bus_if.Branch, bus_if.ALUOp, bus_if.fp_start, bus_if.fp_err};

    localparam logic [13:0] V_FETCH   = 14'b1_0_1_10_10_1_0_0_0_0_0_0;
    localparam logic [13:0] V_DECODE  = 14'b0_0_1_10_10_0_0_0_0_0_0_0;
    localparam logic [13:0] V_RESET   = 14'b0_0_1_10_10_0_0_0_0_0_0_0;
    localparam logic [13:0] V_MEMADR  = 14'b0_0_0_01_00_0_0_0_0_0_0_0;
    localparam logic [13:0] V_MEMRD   = 14'b0_1_0_00_00_0_0_0_0_0_0_0;
    localparam logic [13:0] V_MEMWB   = 14'b0_0_0_00_01_0_1_0_0_0_0_0;
    localparam logic [13:0] V_MEMWR   = 14'b0_1_0_00_00_0_0_1_0_0_0_0;
    localparam logic [13:0] V_EXECR   = 14'b0_0_0_00_00_0_0_0_0_1_0_0;
    localparam logic [13:0] V_EXECI   = 14'b0_0_0_01_00_0_0_0_0_1_0_0;
    localparam logic [13:0] V_ALUWB   = 14'b0_0_0_00_00_0_1_0_0_0_0_0;
    localparam logic [13:0] V_BRANCH  = 14'b0_0_0_01_10_0_0_0_1_0_0_0;
    localparam logic [13:0] V_FPSTART = 14'b0_0_0_00_00_0_0_0_0_1_1_0;
    localparam logic [13:0] V_FPWAIT  = 14'b0_0_0_00_00_0_0_0_0_1_0_0;
    localparam logic [13:0] V_FPABORT = 14'b0_0_0_00_00_0_0_0_0_0_0_1;

    task automatic check(input string tag, input logic [3:0] exp_st, input logic [13:0] exp_v);
        n_tests++;
        assert (bus_if.state_dbg === exp_st) else begin
            n_fail++;
            $error("FAIL %s state: observed %0d expected %0d", tag, bus_if.state_dbg, exp_st);
        end
        n_tests++;
        assert (obs_vec === exp_v) else begin
            n_fail++;
            $error("FAIL %s outputs: observed %b expected %b", tag, obs_vec, exp_v);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] exp_st, input logic [13:0] exp_v);
        @(posedge clk);
        #2;
        check(tag, exp_st, exp_v);
    endtask

    task automatic set_inst(input logic [1:0] op, input logic [5:0] funct);
        bus_if.Op    = op;
        bus_if.Funct = funct;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        bus_if.fp_done = 1'b0;
        set_inst(2'b00, 6'b001000);

        repeat (2) @(negedge clk);
        check("reset", 4'd0, V_RESET);
        reset = 1'b1;
        #1;
        check("add_c0", 4'd0, V_FETCH);
        step("add_c1", 4'd1, V_DECODE);
        step("add_c2", 4'd6, V_EXECR);
        step("add_c3", 4'd8, V_ALUWB);
        step("add_end", 4'd0, V_FETCH);

        set_inst(2'b01, 6'b011001);
        step("ldr_c1", 4'd1, V_DECODE);
        step("ldr_c2", 4'd2, V_MEMADR);
        step("ldr_c3", 4'd3, V_MEMRD);
        step("ldr_c4", 4'd4, V_MEMWB);
        step("ldr_end", 4'd0, V_FETCH);

        set_inst(2'b01, 6'b011000);
        step("str_c1", 4'd1, V_DECODE);
        step("str_c2", 4'd2, V_MEMADR);
        step("str_c3", 4'd5, V_MEMWR);
        step("str_end", 4'd0, V_FETCH);

        set_inst(2'b10, 6'b000000);
        step("b_c1", 4'd1, V_DECODE);
        step("b_c2", 4'd9, V_BRANCH);
        step("b_end", 4'd0, V_FETCH);

        set_inst(2'b00, 6'b101000);
        step("addi_c1", 4'd1, V_DECODE);
        step("addi_c2", 4'd7, V_EXECI);
        step("addi_c3", 4'd8, V_ALUWB);
        step("addi_end", 4'd0, V_FETCH);

        // FP op completing on the third wait cycle
        set_inst(2'b00, 6'b000000);
        step("fp_c1", 4'd1, V_DECODE);
        step("fp_c2", 4'd10, V_FPSTART);
        step("fp_w1", 4'd11, V_FPWAIT);
        step("fp_w2", 4'd11, V_FPWAIT);
        step("fp_w3", 4'd11, V_FPWAIT);
        bus_if.fp_done = 1'b1;
        step("fp_wb", 4'd8, V_ALUWB);
        bus_if.fp_done = 1'b0;
        step("fp_end", 4'd0, V_FETCH);

        // stray fp_done in FETCH with a NOP instruction
        set_inst(2'b11, 6'b000000);
        bus_if.fp_done = 1'b1;
        step("nop_c1", 4'd1, V_DECODE);
        bus_if.fp_done = 1'b0;
        step("nop_end", 4'd0, V_FETCH);

        // FP timeout: four wait cycles then abort
        set_inst(2'b00, 6'b000001);
        step("to_c1", 4'd1, V_DECODE);
        step("to_c2", 4'd10, V_FPSTART);
        step("to_w1", 4'd11, V_FPWAIT);
        step("to_w2", 4'd11, V_FPWAIT);
        step("to_w3", 4'd11, V_FPWAIT);
        step("to_w4", 4'd11, V_FPWAIT);
        step("to_abort", 4'd12, V_FPABORT);
        step("to_end", 4'd0, V_FETCH);

        // reset pulse mid-FPWAIT, then a late fp_done
        set_inst(2'b00, 6'b000000);
        step("rs_c1", 4'd1, V_DECODE);
        step("rs_c2", 4'd10, V_FPSTART);
        step("rs_w1", 4'd11, V_FPWAIT);
        reset = 1'b0;
        #1;
        check("rs_async", 4'd0, V_RESET);
        step("rs_hold", 4'd0, V_RESET);
        @(negedge clk);
        reset = 1'b1;
        bus_if.fp_done = 1'b1;
        #1;
        check("rs_rel", 4'd0, V_FETCH);
        step("rs_c1b", 4'd1, V_DECODE);
        bus_if.fp_done = 1'b0;
        step("rs_c2b", 4'd10, V_FPSTART);
        step("rs_w1b", 4'd11, V_FPWAIT);
        step("rs_w2b", 4'd11, V_FPWAIT);
        step("rs_w3b", 4'd11, V_FPWAIT);
        step("rs_w4b", 4'd11, V_FPWAIT);
        step("rs_abort", 4'd12, V_FPABORT);
        step("rs_end", 4'd0, V_FETCH);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main sequencing FSM for the multicycle build of the ARM-subset processor.
- Steps the shared datapath (one ALU, one memory port, PC/IR registers) through fetch, decode, execute, memory and writeback.
- Also sequences the multicycle floating-point unit with a start/done handshake and a timeout.
- Sits beside the instruction decoder and conditional-write logic. Produces unconditioned strobes; condition gating of RegW, MemW and Branch happens downstream.

Parameters:
- FP_TIMEOUT, 64: maximum cycles spent in FPWAIT before abort; must be ≥ 2.
- CNT_W, 7: width of the FP wait counter; must satisfy 2^CNT_W > FP_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Op  input  2  instruction bits [27:26].
- Funct  input  6  instruction bits [25:20].
- fp_done  input  1  FP unit result valid; single-cycle pulse.
- IRWrite  output  1  load instruction register.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result.
- ALUSrcA  output  1  ALU A select: 0 = register, 1 = PC.
- ALUSrcB  output  2  ALU B select: 00 = register, 01 = immediate, 10 = constant 4.
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result.
- NextPC  output  1  PC write strobe.
- RegW  output  1  register write (unconditioned).
- MemW  output  1  memory write (unconditioned).
- Branch  output  1  branch PC write (unconditioned).
- ALUOp  output  1  decoder uses Funct for ALU control.
- fp_start  output  1  one-cycle start pulse to FP unit.
- fp_err  output  1  one-cycle pulse on FP timeout.
- state_dbg  output  4  current state encoding, for board LEDs.

Behaviour:
- Moore FSM. All outputs decode from the state register, except that every strobe is forced to 0 while reset is low.
  - Strobes: IRWrite, NextPC, RegW, MemW, Branch, fp_start, fp_err.
- Reset: state = FETCH (0), FP counter = 0, state_dbg = 0.
  - Mux outputs while in reset take their FETCH values: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0.
- Reset asserted mid-operation aborts any state, including FPWAIT, with no pending strobe. A late fp_done arriving after reset is ignored.
- FP instruction, fpinst: Op=00 and Funct[5:1]=00000. This overrides register AND.
- State encodings, outputs and next state. Outputs not listed are 0, and don't-care muxes are driven to 0.
  - 0 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1. Next: DECODE.
  - 1 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
    - Op=01 → MEMADR.
    - Op=10 → BRANCH.
    - Op=00 with fpinst → FPSTART.
    - Op=00 with Funct[5]=1 → EXECI.
    - Op=00 otherwise → EXECR.
    - Op=11 → FETCH (treated as NOP).
  - 2 MEMADR: ALUSrcB=01. Next: Funct[0] ? MEMRD : MEMWR.
  - 3 MEMRD: AdrSrc=1. Next: MEMWB.
  - 4 MEMWB: ResultSrc=01, RegW=1. Next: FETCH.
  - 5 MEMWR: AdrSrc=1, MemW=1. Next: FETCH.
  - 6 EXECR: ALUOp=1, ALUSrcB=00. Next: ALUWB.
  - 7 EXECI: ALUOp=1, ALUSrcB=01. Next: ALUWB.
  - 8 ALUWB: ResultSrc=00, RegW=1. Next: FETCH.
  - 9 BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1. Next: FETCH.
  - 10 FPSTART: ALUOp=1, fp_start=1; counter cleared. Next: FPWAIT.
  - 11 FPWAIT: ALUOp=1; counter increments each cycle.
    - fp_done=1 → ALUWB. fp_done has priority when it coincides with the timeout.
    - Otherwise, counter == FP_TIMEOUT-1 → FPABORT.
  - 12 FPABORT: fp_err=1, no register write. Next: FETCH.
  - Encodings 13–15 → FETCH on the next edge; no strobes asserted.
- fp_done outside FPWAIT is ignored.
- Instruction latency in cycles:
  - Data processing: 4.
  - LDR: 5.
  - STR: 4.
  - Branch: 3.
  - FP: 4 + k, where fp_done arrives k cycles after the FPSTART cycle (k ≥ 1).

Decomposition:
- Shared package / include holds:
  - State localparams (FETCH..FPABORT).
  - ALUSrcB and ResultSrc select codes.
  - The fpinst match constant, also used by the decoder's ALUControl=100 path.
- Sub-module: multicycle_ctrl_fpwait, holding the timeout counter and compare, with inputs clear and enable and output expired.
- The output decode stays inline as one case statement.

Test Plan:
- Release reset, then Op=00, Funct=6'b001000 (ADD reg): state sequence 0,1,6,8,0. IRWrite=1 and NextPC=1 only in cycle 0; RegW=1 only in cycle 3.
- Op=01, Funct=6'b011001 (LDR): sequence 0,1,2,3,4,0. AdrSrc=1 in MEMRD; ResultSrc=01 with RegW=1 in MEMWB. Then Funct[0]=0 (STR): MemW=1 exactly one cycle, in state 5.
- Op=10: sequence 0,1,9,0 with Branch=1 for one cycle.
- Op=00, Funct=6'b000000: fp_start pulses once in state 10. fp_done on the 3rd FPWAIT cycle leads to ALUWB with RegW=1, then FETCH. A stray fp_done asserted in FETCH has no effect.
- FP instruction with fp_done never asserted, FP_TIMEOUT=4: exactly 4 FPWAIT cycles, then fp_err=1 for one cycle in state 12, then FETCH with RegW never asserted.
- Drop reset for 1 cycle mid-FPWAIT: strobes go 0 immediately; after release the state is FETCH with the counter at 0.
